// File: rtl/riscv_pkg.sv
// riscv_pkg: state, opcode and datapath-select encodings shared by the multicycle controller
package riscv_pkg;
    typedef logic [3:0] statetype;
    localparam statetype S_FETCH    = 4'd0;
    localparam statetype S_DECODE   = 4'd1;
    localparam statetype S_MEMADR   = 4'd2;
    localparam statetype S_MEMREAD  = 4'd3;
    localparam statetype S_MEMWB    = 4'd4;
    localparam statetype S_MEMWRITE = 4'd5;
    localparam statetype S_EXECUTER = 4'd6;
    localparam statetype S_EXECUTEI = 4'd7;
    localparam statetype S_ALUWB    = 4'd8;
    localparam statetype S_BEQ      = 4'd9;
    localparam statetype S_JAL      = 4'd10;

    typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the controller's aluop plus funct fields to the ALU operation
module alu_decoder
    import riscv_pkg::*;
(
    input  aluop_t     i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alucontrol
);
    logic [2:0] w_funct;
    // op[5] separates R-type from I-type so addi with instr[30] set stays an add
    always_comb begin
        case (i_funct3)
            3'b000:  w_funct = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_funct = ALU_SLT;
            3'b110:  w_funct = ALU_OR;
            3'b111:  w_funct = ALU_AND;
            default: w_funct = ALU_ADD;
        endcase
    end
    assign o_alucontrol = (i_aluop == ALUOP_SUB)   ? ALU_SUB :
                          (i_aluop == ALUOP_FUNCT) ? w_funct : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing ALU, memory port and register file of a
// multicycle RV32I core, with a retired-instruction counter
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             adrsrc,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic [1:0]       resultsrc,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       immsrc,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);
    statetype         r_state;
    statetype         w_next;
    aluop_t           w_aluop;
    logic             w_retire;
    logic [CNT_W-1:0] r_instret;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   w_next = (op == OP_LW || op == OP_SW) ? S_MEMADR   :
                                 (op == OP_R)                 ? S_EXECUTER :
                                 (op == OP_I)                 ? S_EXECUTEI :
                                 (op == OP_BEQ)               ? S_BEQ      :
                                 (op == OP_JAL)               ? S_JAL      : S_FETCH;
            S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    always_comb begin
        pcwrite   = 1'b0;
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        resultsrc = RES_ALUOUT;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        w_aluop   = ALUOP_ADD;
        illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                irwrite   = mem_ready;
                pcwrite   = mem_ready;
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                illegal = !(op == OP_LW || op == OP_SW || op == OP_R || op == OP_I ||
                            op == OP_BEQ || op == OP_JAL);
            end
            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
            end
            S_MEMREAD: adrsrc = 1'b1;
            S_MEMWB: begin
                resultsrc = RES_DATA;
                regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTER: begin
                alusrca = SRCA_RS1;
                w_aluop = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                w_aluop = ALUOP_FUNCT;
            end
            S_ALUWB: regwrite = 1'b1;
            S_BEQ: begin
                alusrca = SRCA_RS1;
                w_aluop = ALUOP_SUB;
                pcwrite = zero;
            end
            S_JAL: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_FOUR;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign immsrc = (op == OP_SW)  ? IMM_S :
                    (op == OP_BEQ) ? IMM_B :
                    (op == OP_JAL) ? IMM_J : IMM_I;

    alu_decoder u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct3     (funct3),
        .i_op5        (op[5]),
        .i_funct7b5   (funct7b5),
        .o_alucontrol (alucontrol)
    );

    // an illegal op returns to FETCH straight from DECODE and so never retires
    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                      (r_state == S_MEMWRITE && mem_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end

    assign instret = r_instret;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench; expected control vectors queued per cycle
module tb_multicycle_controller;
    logic        clk;
    logic        reset_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0]  resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0]  alucontrol;
    logic [31:0] instret;
    logic [16:0] obs;

    typedef struct {
        string       tag;
        logic [16:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] exp_cnt;
    int          n_checks;
    int          n_fail;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .resultsrc  (resultsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .immsrc     (immsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .instret    (instret)
    );

    assign obs = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
                  alusrca, alusrcb, immsrc, alucontrol, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ctl(input logic pcw, adr, mw, irw, rw,
                                        input logic [1:0] rs, a, b, imm,
                                        input logic [2:0] alu, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ill};
    endfunction

    function automatic logic [16:0] f_fetch(input logic r, input logic [1:0] imm);
        return ctl(r, 0, 0, r, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    endfunction
    function automatic logic [16:0] f_decode(input logic [1:0] imm, input logic ill);
        return ctl(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, ill);
    endfunction
    function automatic logic [16:0] f_memadr(input logic [1:0] imm);
        return ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0);
    endfunction
    function automatic logic [16:0] f_memread();
        return ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [16:0] f_memwb();
        return ctl(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [16:0] f_memwrite();
        return ctl(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
    endfunction
    function automatic logic [16:0] f_execr(input logic [2:0] alu);
        return ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0);
    endfunction
    function automatic logic [16:0] f_execi(input logic [2:0] alu);
        return ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0);
    endfunction
    function automatic logic [16:0] f_aluwb(input logic [1:0] imm);
        return ctl(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
    endfunction
    function automatic logic [16:0] f_beq(input logic z);
        return ctl(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);
    endfunction
    function automatic logic [16:0] f_jal();
        return ctl(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0);
    endfunction

    task automatic step(input string tag, input logic [16:0] c);
        sb.push_back('{tag, c, exp_cnt});
        @(posedge clk);
        #1;
    endtask

    task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic [2:0] alu);
        op = o; funct3 = f3; funct7b5 = f7;
        step({tag, "_f"}, f_fetch(1, 2'b00));
        step({tag, "_d"}, f_decode(2'b00, 0));
        step({tag, "_x"}, (o == 7'b0110011) ? f_execr(alu) : f_execi(alu));
        step({tag, "_wb"}, f_aluwb(2'b00));
        exp_cnt++;
    endtask

    task automatic lw_instr(input string tag);
        op = 7'b0000011;
        step({tag, "_f"}, f_fetch(1, 2'b00));
        step({tag, "_d"}, f_decode(2'b00, 0));
        step({tag, "_a"}, f_memadr(2'b00));
        step({tag, "_r"}, f_memread());
        step({tag, "_wb"}, f_memwb());
        exp_cnt++;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "/ctl"}, 64'(obs), 64'(e.ctl));
            check({e.tag, "/instret"}, 64'(instret), 64'(e.cnt));
        end
    end

    initial begin
        n_checks = 0; n_fail = 0; exp_cnt = '0;
        reset_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step("rst", f_fetch(0, 2'b00));
        reset_n = 1'b1;
        step("idle", f_fetch(0, 2'b00));
        mem_ready = 1'b1;
        lw_instr("lw");
        op = 7'b0100011;
        step("sw_f", f_fetch(1, 2'b01));
        step("sw_d", f_decode(2'b01, 0));
        step("sw_a", f_memadr(2'b01));
        mem_ready = 1'b0;
        step("sw_w0", f_memwrite());
        step("sw_w1", f_memwrite());
        mem_ready = 1'b1;
        step("sw_w2", f_memwrite());
        exp_cnt++;
        for (int i = 0; i < 2; i++) begin
            op = 7'b1100011; zero = (i == 0);
            step("beq_f", f_fetch(1, 2'b10));
            step("beq_d", f_decode(2'b10, 0));
            step(i == 0 ? "beq_z1" : "beq_z0", f_beq(zero));
            exp_cnt++;
        end
        zero = 1'b0;
        alu_instr("sub",  7'b0110011, 3'b000, 1, 3'b001);
        alu_instr("add",  7'b0110011, 3'b000, 0, 3'b000);
        alu_instr("or",   7'b0110011, 3'b110, 0, 3'b011);
        alu_instr("slt",  7'b0110011, 3'b010, 0, 3'b101);
        alu_instr("addi", 7'b0010011, 3'b000, 1, 3'b000);
        alu_instr("andi", 7'b0010011, 3'b111, 0, 3'b010);
        alu_instr("xori", 7'b0010011, 3'b100, 0, 3'b000);
        op = 7'b1101111;
        step("jal_f", f_fetch(1, 2'b11));
        step("jal_d", f_decode(2'b11, 0));
        step("jal_j", f_jal());
        step("jal_wb", f_aluwb(2'b11));
        exp_cnt++;
        op = 7'b1111111;
        step("ill_f", f_fetch(1, 2'b00));
        step("ill_d", f_decode(2'b00, 1));
        op = 7'b0100011;
        step("rsw_f", f_fetch(1, 2'b01));
        step("rsw_d", f_decode(2'b01, 0));
        step("rsw_a", f_memadr(2'b01));
        mem_ready = 1'b0;
        #1;
        check("rsw_pre_memwrite", 64'(memwrite), 64'd1);
        reset_n = 1'b0;
        #1;
        exp_cnt = '0;
        check("rsw_memwrite", 64'(memwrite), 64'd0);
        check("rsw_regwrite", 64'(regwrite), 64'd0);
        check("rsw_ctl", 64'(obs), 64'(f_fetch(0, 2'b01)));
        check("rsw_instret", 64'(instret), 64'(exp_cnt));
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_idle", f_fetch(0, 2'b01));
        mem_ready = 1'b1;
        lw_instr("lw2");
        op = 7'b0000000;
        step("end_f", f_fetch(1, 2'b00));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
